// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: digit count,
// logical {g,f,e,d,c,b,a} segment patterns and the overflow digit code.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] DIGIT_OVF = 4'hF;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Four-digit BCD bus from the trigger/counter block to the display driver.
// master: producer drives BCD3..BCD0; slave: scan driver samples them.
interface seg7_scan_driver_if;

    logic [3:0] BCD0;
    logic [3:0] BCD1;
    logic [3:0] BCD2;
    logic [3:0] BCD3;

    modport master (
        output BCD0,
        output BCD1,
        output BCD2,
        output BCD3
    );

    modport slave (
        input BCD0,
        input BCD1,
        input BCD2,
        input BCD3
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational digit decoder: 4-bit code -> logical active-high {g..a}.
// Ports: code (in, 4), pattern (out, 7). 0-9 digits, F dash, A-E blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        unique case (code)
            4'd0:      pattern = SEG_0;
            4'd1:      pattern = SEG_1;
            4'd2:      pattern = SEG_2;
            4'd3:      pattern = SEG_3;
            4'd4:      pattern = SEG_4;
            4'd5:      pattern = SEG_5;
            4'd6:      pattern = SEG_6;
            4'd7:      pattern = SEG_7;
            4'd8:      pattern = SEG_8;
            4'd9:      pattern = SEG_9;
            DIGIT_OVF: pattern = SEG_DASH;
            default:   pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with per-scan input snapshot.
// Ports: Clk, Reset (sync, active-high), bcd (slave BCD3..BCD0 bus),
//   Seg[6:0] {g..a}, An[3:0] digit enables, ScanDone (end-of-scan pulse).
// Seg/An polarity set by ACTIVE_LOW. Define SEG7_LEADING_ZERO_BLANK_EN to
// blank leading zeros on digits 3..1.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    seg7_scan_driver_if.slave   bcd,
    output logic [6:0]          Seg,
    output logic [3:0]          An,
    output logic                ScanDone
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [6:0]    SEG_INV   = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0]    AN_INV    = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    logic [CW-1:0]                  cnt;
    logic [1:0]                     idx;
    logic [NUM_DIGITS-1:0][3:0]     snap;

    logic [3:0] cur_code;
    logic [6:0] dec_pat;
    logic [6:0] seg_log;
    logic [3:0] an_log;
    logic       slot_end;
    logic       scan_end;

    assign cur_code = snap[idx];
    assign slot_end = (cnt == CNT_MAX);
    assign scan_end = slot_end && (idx == 2'd3);

    seg7_decode u_decode (
        .code    (cur_code),
        .pattern (dec_pat)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // lz[i]: digit i and every higher digit are zero; digit 0 always shows.
    logic [NUM_DIGITS-1:0] lz;

    always_comb begin
        lz    = '0;
        lz[3] = (snap[3] == 4'd0);
        lz[2] = lz[3] && (snap[2] == 4'd0);
        lz[1] = lz[2] && (snap[1] == 4'd0);
        seg_log = lz[idx] ? SEG_BLANK : dec_pat;
    end
`else
    always_comb begin
        seg_log = dec_pat;
    end
`endif

    // Segments stay driven through the blank window; only anodes are gated.
    always_comb begin
        an_log = 4'b0000;
        if (cnt >= CNT_BLANK)
            an_log = 4'b0001 << idx;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt      <= '0;
            idx      <= 2'd0;
            snap     <= '0;
            Seg      <= SEG_BLANK ^ SEG_INV;
            An       <= AN_INV;
            ScanDone <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // One coherent capture per scan so digits never tear mid-scan.
            if (cnt == '0 && idx == 2'd0)
                snap <= {bcd.BCD3, bcd.BCD2, bcd.BCD1, bcd.BCD0};
            Seg      <= seg_log ^ SEG_INV;
            An       <= an_log ^ AN_INV;
            ScanDone <= scan_end;
        end
    end

endmodule
